// File: rtl/cfs_apb_master_arbiter.sv
// cfs_apb_master_arbiter
// Round-robin APB master shared by NUM_REQ local requesters. Each requester
// issues single commands over valid/ready. The block runs the APB setup and
// access phases (back-to-back when another command is waiting), returns read
// data / error status to the owner, and aborts accesses that exceed TIMEOUT
// wait cycles.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | bus idle, psel=0; arbitration window open
//   ST_SETUP  | psel=1, penable=0; captured command on the bus
//   ST_ACCESS | psel=1, penable=1; waiting for pready (window when pready=1)

module cfs_apb_master_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic                          psel,
  output logic                          penable,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // A zero TIMEOUT would give a zero-width counter; keep one bit so the
  // register still exists (it simply saturates and is never compared).
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Timeout fires on the access cycle in which the count would reach TIMEOUT.
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]            r_state;
  logic [GW-1:0]         r_last_grant;
  logic [CW-1:0]         r_wait_cnt;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_window;
  logic                  w_found;
  logic [GW-1:0]         w_win_idx;
  logic                  w_grant;
  logic                  w_done;
  logic                  w_timeout;
  logic [ADDR_WIDTH-1:0] w_cap_addr;
  logic [DATA_WIDTH-1:0] w_cap_wdata;
  logic                  w_cap_write;

  // Requester index k positions after base, wrapping at NUM_REQ.
  function automatic logic [GW-1:0] f_next(input logic [GW-1:0] base, input int k);
    int t;
    t = (int'(base) + k) % NUM_REQ;
    return GW'(t);
  endfunction

  assign w_window  = (r_state == ST_IDLE) || ((r_state == ST_ACCESS) && pready);
  assign w_done    = (r_state == ST_ACCESS) && pready;
  assign w_timeout = (TIMEOUT != 0) && (r_state == ST_ACCESS) && !pready &&
                     (r_wait_cnt == TO_LAST);
  assign w_grant   = w_window && w_found;

  assign w_cap_addr  = req_addr[int'(w_win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_cap_wdata = req_wdata[int'(w_win_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_cap_write = req_write[w_win_idx];

  // Round-robin search starting just after the last winner.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = r_last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req_valid[f_next(r_last_grant, k)]) begin
        w_found   = 1'b1;
        w_win_idx = f_next(r_last_grant, k);
      end
    end
  end

  // One-hot accept, only inside an arbitration window.
  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_win_idx] = 1'b1;
  end

  // Bus sequencing FSM, wait counter and registered APB outputs.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_wait_cnt   <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          if (w_grant) begin
            r_state      <= ST_SETUP;
            r_psel       <= 1'b1;
            r_paddr      <= w_cap_addr;
            r_pwrite     <= w_cap_write;
            r_pwdata     <= w_cap_write ? w_cap_wdata : '0;
            r_last_grant <= w_win_idx;
          end
        end
        ST_SETUP: begin
          r_state    <= ST_ACCESS;
          r_penable  <= 1'b1;
          r_wait_cnt <= '0;
        end
        ST_ACCESS: begin
          if (pready) begin
            if (w_grant) begin
              // Back-to-back: psel stays high, straight into the next setup.
              r_state      <= ST_SETUP;
              r_penable    <= 1'b0;
              r_paddr      <= w_cap_addr;
              r_pwrite     <= w_cap_write;
              r_pwdata     <= w_cap_write ? w_cap_wdata : '0;
              r_last_grant <= w_win_idx;
            end else begin
              r_state   <= ST_IDLE;
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state   <= ST_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
          end else if (r_wait_cnt != {CW{1'b1}}) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle response pulse to the owner of the finishing access.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      if (w_done) begin
        r_rsp_valid[r_last_grant] <= 1'b1;
        r_rsp_err                 <= pslverr;
        r_rsp_rdata               <= r_pwrite ? '0 : prdata;
      end else if (w_timeout) begin
        r_rsp_valid[r_last_grant] <= 1'b1;
        r_rsp_err                 <= 1'b1;
      end
    end
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_cfs_apb_master_arbiter.sv
// Testbench for cfs_apb_master_arbiter: directed commands, expected responses
// queued at issue time and checked by an independent response monitor.

module tb_cfs_apb_master_arbiter;

  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 32;

  logic              pclk;
  logic              preset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [AW-1:0]     paddr;
  logic              pwrite;
  logic [DW-1:0]     pwdata;
  logic              psel;
  logic              penable;
  logic [DW-1:0]     prdata;
  logic              pready;
  logic              pslverr;

  cfs_apb_master_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave model controls
  int          slv_waits = 0;
  logic        slv_stuck = 1'b0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc_cnt;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign pready  = psel && penable && !slv_stuck && (acc_cnt >= slv_waits);
  assign prdata  = pready ? slv_rdata : '0;
  assign pslverr = pready && slv_err;

  // Response monitor plus paddr stability during the access phase.
  logic [AW-1:0] setup_addr;
  always @(negedge pclk) begin
    exp_t e;
    logic [NR-1:0] oh;
    if (preset_n) begin
      if (psel && !penable) setup_addr = paddr;
      if (psel && penable) begin
        checks++;
        if (paddr !== setup_addr) begin
          errors++;
          $display("FAIL paddr_stable cyc=%0d got %h want %h", cyc, paddr, setup_addr);
        end
      end
      if (rsp_valid !== '0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp cyc=%0d rsp_valid=%b", cyc, rsp_valid);
        end else begin
          e = q.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          if (rsp_valid !== oh || rsp_rdata !== e.rdata || rsp_err !== e.err || cyc != e.cyc) begin
            errors++;
            $display("FAIL rsp got valid=%b rdata=%h err=%b cyc=%0d want valid=%b rdata=%h err=%b cyc=%0d",
                     rsp_valid, rsp_rdata, rsp_err, cyc, oh, e.rdata, e.err, e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h want %h", name, cyc, got, want);
    end
  endtask

  // Issue one command; push the expected response (lat cycles after accept).
  task automatic do_cmd(input int idx, input bit wr, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bit exp_err, input int lat, input bit push,
                        output int acc);
    exp_t e;
    bit ok;
    ok = 1'b0;
    acc = -1;
    @(negedge pclk);
    req_write[idx] = wr;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = wd;
    req_valid[idx] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout req=%0d got no ready want ready", idx);
    end else begin
      acc = cyc;
      if (push) begin
        e.idx = idx; e.rdata = exp_rd; e.err = exp_err; e.cyc = acc + lat;
        q.push_back(e);
      end
    end
    @(posedge pclk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 100; n++) begin
      if (q.size() == 0) break;
      @(negedge pclk);
      #2;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int n = 0; n < 60 && cyc < target; n++) @(negedge pclk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int acc, c0, k0, k1, drops, tog;
    logic [NR-1:0] rdy;
    exp_t e;

    preset_n  = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge pclk);
    check("reset_outputs",
          {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, req_ready},
          '0);
    preset_n = 1'b1;

    // single write, zero-wait
    do_cmd(0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1'b1, acc);
    wait_cyc(acc + 1);
    check("write_setup", {psel, penable, pwrite, paddr, pwdata}, {3'b101, 16'h0010, 32'hDEADBEEF});
    wait_cyc(acc + 2);
    check("write_access", {psel, penable}, 2'b11);
    wait_done();

    // read with 3 wait states
    slv_waits = 3;
    slv_rdata = 32'h12345678;
    do_cmd(1, 1'b0, 16'h0004, 32'hFFFFFFFF, 32'h12345678, 1'b0, 6, 1'b1, acc);
    wait_cyc(acc + 1);
    check("read_setup", {psel, penable, pwrite, paddr, pwdata}, {3'b100, 16'h0004, 32'h0});
    wait_done();
    slv_waits = 0;

    // contention: 4 commands each, alternating grants 0,1,0,1...
    slv_rdata = 32'hCAFE0001;
    @(negedge pclk);
    c0 = cyc;
    for (int j = 0; j < 8; j++) begin
      e.idx = j % 2; e.rdata = (j % 2) ? 32'hCAFE0001 : 32'h0; e.err = 1'b0; e.cyc = c0 + 3 + 2*j;
      q.push_back(e);
    end
    k0 = 0; k1 = 0; drops = 0; tog = 0;
    for (int n = 0; n < 18; n++) begin
      req_valid[0] = (k0 < 4);
      req_write[0] = 1'b1;
      req_addr[0*AW +: AW]  = 16'h0100 + 16'(k0*4);
      req_wdata[0*DW +: DW] = 32'(k0);
      req_valid[1] = (k1 < 4);
      req_write[1] = 1'b0;
      req_addr[1*AW +: AW]  = 16'h0200 + 16'(k1*4);
      #1;
      rdy = req_ready;
      if (cyc > c0 && cyc <= c0 + 16) begin
        if (!psel) drops++;
        if (penable != ((cyc - c0) % 2 == 0)) tog++;
      end
      if (rdy[0]) k0++;
      if (rdy[1]) k1++;
      @(negedge pclk);
    end
    req_valid = '0;
    check("b2b_psel_drops", 64'(drops), 64'd0);
    check("b2b_penable_toggle", 64'(tog), 64'd0);
    check("b2b_accepts", {32'(k0), 32'(k1)}, {32'd4, 32'd4});
    wait_done();

    // slave error, then a normal transfer
    slv_err = 1'b1;
    do_cmd(0, 1'b1, 16'h0020, 32'h11111111, 32'h0, 1'b1, 3, 1'b1, acc);
    wait_done();
    slv_err = 1'b0;
    slv_rdata = 32'h0BADF00D;
    do_cmd(1, 1'b0, 16'h0024, 32'h0, 32'h0BADF00D, 1'b0, 3, 1'b1, acc);
    wait_done();

    // timeout: 16 access cycles with pready stuck low
    slv_stuck = 1'b1;
    do_cmd(0, 1'b0, 16'h0050, 32'h0, 32'h0, 1'b1, 18, 1'b1, acc);
    wait_cyc(acc + 17);
    check("timeout_last_access", {psel, penable}, 2'b11);
    wait_cyc(acc + 18);
    check("timeout_psel_drop", {psel, penable}, 2'b00);
    wait_done();
    slv_stuck = 1'b0;
    wait_cyc(acc + 19);
    check("timeout_idle", {psel, penable}, 2'b00);

    // reset in the middle of an access
    slv_stuck = 1'b1;
    do_cmd(1, 1'b0, 16'h0060, 32'h0, 32'h0, 1'b0, 0, 1'b0, acc);
    wait_cyc(acc + 4);
    check("pre_reset_access", {psel, penable}, 2'b11);
    preset_n = 1'b0;
    #1;
    check("async_reset_clear", {psel, penable, rsp_valid}, '0);
    slv_stuck = 1'b0;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    req_write = 2'b01;
    req_addr  = {16'h0040, 16'h0030};
    req_wdata = {32'h0, 32'h00000055};
    req_valid = 2'b11;
    #1;
    check("post_reset_priority", req_ready, 2'b01);
    e.idx = 0; e.rdata = 32'h0; e.err = 1'b0; e.cyc = cyc + 3;
    q.push_back(e);
    @(posedge pclk);
    #1;
    req_valid = '0;
    wait_done();
    repeat (3) @(negedge pclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfs_apb_master_arbiter.md
# cfs_apb_master_arbiter

Round-robin APB master that shares one APB bus between NUM_REQ local requesters. Each requester issues single read/write commands over a valid/ready handshake. The block sequences the APB setup and access phases, optionally back-to-back, and returns read data and error status to the granted requester. A programmable timeout terminates accesses when the slave never asserts pready. It sits between the register-access clients and the APB slave interface, and drives the bus so that all interface protocol and X-checks pass.

## Interface
- NUM_REQ, 2: number of requesters, 1..8
- ADDR_WIDTH, 16: paddr width
- DATA_WIDTH, 32: pwdata/prdata width
- TIMEOUT, 16: max access-phase cycles waiting for pready; 0 disables timeout
- pclk  in  1  clock; everything is sampled on its rising edge
- preset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  one-hot command accept (combinational)
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i uses slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts
- rsp_err  out  1  pslverr, or 1 on timeout
- paddr, pwrite, pwdata, psel, penable  out  ADDR_WIDTH/1/DATA_WIDTH/1/1  APB master outputs, all registered
- prdata, pready, pslverr  in  DATA_WIDTH/1/1  APB slave returns

## Operation
- **States:** IDLE, SETUP, ACCESS.
- **Arbitration windows:**
  - A window exists in IDLE, and in ACCESS during the cycle pready=1.
  - The search starts at last_grant+1 mod NUM_REQ. The first asserted req_valid wins.
  - In that cycle req_ready[winner]=1, and addr/write/wdata are captured. last_grant updates to the winner.
  - req_ready is 0 outside a window.
- **IDLE:**
  - psel=0, penable=0.
  - On a grant, go to SETUP.
- **SETUP:**
  - psel=1, penable=0; paddr/pwrite are the captured values.
  - pwdata is the captured wdata on writes and 0 on reads.
  - Always go to ACCESS.
- **ACCESS:**
  - psel=1, penable=1; paddr/pwrite/pwdata are held stable.
  - If pready=1: next cycle rsp_valid[granted]=1, rsp_err=pslverr, and rsp_rdata=prdata (reads only). Then:
    - If a new grant occurs in the same cycle, go to SETUP (psel stays 1, penable falls to 0).
    - Otherwise go to IDLE.
  - If pready=0: the wait counter increments.
    - When TIMEOUT≠0 and the counter reaches TIMEOUT with pready still 0: next cycle rsp_valid pulses with rsp_err=1 and rsp_rdata=0.
    - psel and penable drop to 0 and the state goes to IDLE. There is no back-to-back after a timeout.
- **Wait counter:**
  - Width is $clog2(TIMEOUT+1).
  - Cleared on entry to ACCESS. Saturates and never wraps.
- **NUM_REQ=1:** arbitration degenerates to a pass-through.

## Timing
- **Reset:** while preset_n=0, all of the following are 0: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, and the wait counter. The state is IDLE and last_grant=NUM_REQ-1, so requester 0 has first priority.
- **Reset mid-transaction:** all outputs clear immediately (asynchronously). The in-flight command is dropped with no response. After release, the block starts in IDLE.
- **Latency (zero-wait slave):**
  - Accept at cycle T.
  - psel=1 at T+1.
  - penable=1 at T+2.
  - rsp_valid at T+3.
  - Each pready=0 cycle adds 1.
- **Back-to-back:** throughput is one transfer per 2 cycles. psel never deasserts between transfers.
- rsp_valid is exactly one cycle wide and is never held for backpressure. Requesters must accept it.
- Requesters hold req_valid and the command stable until req_ready. A requester may drop req_valid without penalty.
- A requester may issue a new command in the same cycle its previous response arrives.
- Responses are in order, at most one outstanding.

## Test plan
- **Single write:** requester 0 writes addr 0x0010, data 0xDEADBEEF to a zero-wait slave.
  - psel rises at T+1, penable at T+2.
  - rsp_valid=01 at T+3 with rsp_err=0 and rsp_rdata=0.
- **Read with waits:** requester 1 reads 0x0004; the slave holds pready=0 for 3 cycles, then returns prdata=0x12345678.
  - rsp_rdata=0x12345678 at T+6.
  - paddr stays stable throughout the access phase.
- **Contention:** both requesters hold valid for 4 commands each.
  - Grants alternate 0,1,0,1…
  - psel stays 1 across transfers; penable toggles 0/1.
- **Slave error:** pslverr=1 with pready=1 on a write.
  - rsp_err=1 and the next transfer proceeds normally.
- **Timeout:** with TIMEOUT=16 and pready stuck at 0:
  - After 16 access cycles, rsp_err=1 and rsp_rdata=0.
  - psel=0 the following cycle; the state is IDLE.
- **Mid-access reset:** preset_n is pulled low during ACCESS.
  - psel, penable and rsp_valid go to 0 immediately, with no response.
  - After release, requester 0 is granted first.
